// File: rtl/mem_arb.sv
// mem_arb: shares one single-port synchronous memory between IF and DM; define ARB_STATS_EN for grant/conflict counters
module mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_sel,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_dm_cnt,
    output logic [31:0]       stat_conf_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t            state;
    logic [CW-1:0]     lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              own_dm;
    logic              cmd_we;
    logic [3:0]        cmd_sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] dm_hold;
    logic              done;
    logic              can_gnt;
    logic              force_if;

    // lat_cnt holds the WAIT cycles still to go, so completion is the cycle it reads zero
    assign done     = state == WAIT && lat_cnt == '0;
    // gating with rst keeps the grants low while reset is asserted
    assign can_gnt  = rst && (state == IDLE || done);
    assign force_if = starve_cnt == SW'(STARVE_MAX);
    assign dm_gnt   = can_gnt && dm_req && !(if_req && force_if);
    assign if_gnt   = can_gnt && if_req && !dm_gnt;
    assign busy     = state != IDLE;
    assign mem_ce   = state == ISSUE;
    assign mem_we   = mem_ce && cmd_we;
    assign mem_sel  = cmd_sel;
    assign mem_addr = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign if_valid = done && !own_dm;
    assign dm_valid = done && own_dm;
    // read data passes straight through on the valid cycle, then the hold register keeps it
    assign if_rdata = if_valid ? mem_rdata : if_hold;
    assign dm_rdata = dm_valid ? (cmd_we ? '0 : mem_rdata) : dm_hold;

    // access sequencer: latch the winner's command on grant, then issue and time the read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            own_dm    <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_sel   <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (if_gnt || dm_gnt) begin
            state     <= ISSUE;
            own_dm    <= dm_gnt;
            cmd_we    <= dm_gnt && dm_we;
            cmd_sel   <= dm_gnt ? dm_sel : 4'hF;
            cmd_addr  <= dm_gnt ? dm_addr : if_addr;
            cmd_wdata <= dm_gnt ? dm_wdata : '0;
        end else if (state == ISSUE) begin
            state   <= WAIT;
            lat_cnt <= CW'(MEM_LAT - 1);
        end else if (state == WAIT) begin
            state   <= done ? IDLE : WAIT;
            lat_cnt <= lat_cnt - CW'(1);
        end
    end

    // count DM wins against a waiting IF so IF is forced through after STARVE_MAX of them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (if_gnt || !if_req)
            starve_cnt <= '0;
        else if (dm_gnt && !force_if)
            starve_cnt <= starve_cnt + SW'(1);
    end

    // keep the last returned word on each requester's data output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_hold <= '0;
            dm_hold <= '0;
        end else begin
            if (if_valid)
                if_hold <= mem_rdata;
            if (dm_valid)
                dm_hold <= cmd_we ? '0 : mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    // saturating grant and conflict counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || stat_clr) begin
            stat_if_cnt   <= '0;
            stat_dm_cnt   <= '0;
            stat_conf_cnt <= '0;
        end else begin
            if (if_gnt && ~&stat_if_cnt)
                stat_if_cnt <= stat_if_cnt + 32'd1;
            if (dm_gnt && ~&stat_dm_cnt)
                stat_dm_cnt <= stat_dm_cnt + 32'd1;
            if (if_req && dm_req && !if_gnt && !dm_gnt && ~&stat_conf_cnt)
                stat_conf_cnt <= stat_conf_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: two arbiter lanes (MEM_LAT 1 and 3) driven by directed and random traffic against a cycle model
module tb_mem_arb;
    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   fin [2];

    always #5 clk = ~clk;

    task automatic chk(input int ln, input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %h expected %h at %0t", ln, n, act, exp, $time);
        end
    endtask

    // memory contents are a fixed function of the address
    function automatic logic [31:0] hsh(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = g == 0 ? 1 : 3;
        logic        rst, if_req, if_gnt, if_valid, dm_req, dm_we, dm_gnt, dm_valid, mem_ce, mem_we, busy;
        logic [3:0]  dm_sel, mem_sel;
        logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [31:0] noise, rd_val;
        int          rd_cnt = 0;
        logic        ig, dg;
        int          n;
        int          age = 0, starve = 0;
        bit          own_dm = 0, c_we = 0;
        logic [3:0]  c_sel = '0;
        logic [31:0] c_addr = '0, c_wdata = '0, h_if = '0, h_dm = '0;
`ifdef ARB_STATS_EN
        logic        stat_clr;
        logic [31:0] stat_if_cnt, stat_dm_cnt, stat_conf_cnt;
        int          m_si = 0, m_sd = 0, m_sc = 0;
`endif

        mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(4)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
            .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
            .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
            , .stat_clr(stat_clr), .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt), .stat_conf_cnt(stat_conf_cnt)
`endif
        );

        // memory: read data appears L cycles after the command strobe, noise otherwise
        assign mem_rdata = rd_cnt == 1 ? rd_val : noise;
        always @(posedge clk) begin
            if (mem_ce && !mem_we) begin
                rd_val <= hsh(mem_addr);
                rd_cnt <= L;
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
            end
        end

        // model: an access occupies ages 1..L+1 after its grant; completion age L+1 may grant again
        always @(negedge clk) begin
            bit dn, can, dw, iw;
            logic [31:0] rd;
            if (!rst) begin
                chk(g, "reset_outputs_zero", 32'(|{if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
                    mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, busy}), 32'd0);
                age = 0; starve = 0; h_if = '0; h_dm = '0;
`ifdef ARB_STATS_EN
                chk(g, "reset_stats_zero", 32'(|{stat_if_cnt, stat_dm_cnt, stat_conf_cnt}), 32'd0);
                m_si = 0; m_sd = 0; m_sc = 0;
`endif
            end else begin
                dn  = age == L + 1;
                can = age == 0 || dn;
                dw  = can && dm_req && !(if_req && starve == 4);
                iw  = can && if_req && !dw;
                rd  = hsh(c_addr);
                chk(g, "if_gnt", 32'(if_gnt), 32'(iw));
                chk(g, "dm_gnt", 32'(dm_gnt), 32'(dw));
                chk(g, "if_valid", 32'(if_valid), 32'(dn && !own_dm));
                chk(g, "dm_valid", 32'(dm_valid), 32'(dn && own_dm));
                chk(g, "if_rdata", if_rdata, (dn && !own_dm) ? rd : h_if);
                chk(g, "dm_rdata", dm_rdata, (dn && own_dm) ? (c_we ? 32'd0 : rd) : h_dm);
                chk(g, "busy", 32'(busy), 32'(age > 0));
                chk(g, "mem_ce", 32'(mem_ce), 32'(age == 1));
                chk(g, "mem_we", 32'(mem_we), 32'(age == 1 && c_we));
                if (age == 1) chk(g, "mem_addr", mem_addr, c_addr);
                if (age == 1 && c_we) begin
                    chk(g, "mem_sel", 32'(mem_sel), 32'(c_sel));
                    chk(g, "mem_wdata", mem_wdata, c_wdata);
                end
`ifdef ARB_STATS_EN
                chk(g, "stat_if_cnt", stat_if_cnt, m_si);
                chk(g, "stat_dm_cnt", stat_dm_cnt, m_sd);
                chk(g, "stat_conf_cnt", stat_conf_cnt, m_sc);
                if (stat_clr) begin
                    m_si = 0; m_sd = 0; m_sc = 0;
                end else begin
                    m_si += int'(iw);
                    m_sd += int'(dw);
                    m_sc += int'(if_req && dm_req && !iw && !dw);
                end
`endif
                if (dn && own_dm) h_dm = c_we ? 32'd0 : rd;
                if (dn && !own_dm) h_if = rd;
                if (iw || dw) begin
                    age = 1; own_dm = dw; c_we = dw && dm_we; c_sel = dm_sel;
                    c_addr = dw ? dm_addr : if_addr; c_wdata = dm_wdata;
                end else if (dn) age = 0;
                else if (age > 0) age++;
                if (iw || !if_req) starve = 0;
                else if (dw && starve < 4) starve++;
            end
        end

        initial begin
            rst = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_sel = '0; dm_addr = '0; dm_wdata = '0;
            noise = 32'h0BAD_0BAD;
`ifdef ARB_STATS_EN
            stat_clr = 0;
`endif
            repeat (3) @(posedge clk);
            #1 rst = 1;
            // IF alone at 0x100
            if_addr = 32'h100; if_req = 1;
            @(negedge clk); chk(g, "if_alone_gnt", 32'(if_gnt), 32'd1);
            @(posedge clk); #1 if_req = 0;
            @(negedge clk); chk(g, "if_alone_ce", 32'(mem_ce), 32'd1); chk(g, "if_alone_addr", mem_addr, 32'h100);
            repeat (L) @(negedge clk);
            chk(g, "if_alone_valid", 32'(if_valid), 32'd1); chk(g, "if_alone_rdata", if_rdata, 32'hC2A5_5A3C);
            // simultaneous IF and DM read: DM first, IF granted on DM completion
            @(posedge clk); #1 if_addr = 32'h104; if_req = 1; dm_addr = 32'h2000; dm_we = 0; dm_sel = 4'hF; dm_req = 1;
            @(negedge clk); chk(g, "both_dm_gnt", 32'(dm_gnt), 32'd1); chk(g, "both_if_held", 32'(if_gnt), 32'd0);
            @(posedge clk); #1 dm_req = 0;
            @(negedge clk); chk(g, "both_ce1", 32'(mem_ce), 32'd1); chk(g, "both_addr1", mem_addr, 32'h2000);
            repeat (L) @(negedge clk);
            chk(g, "both_dm_valid", 32'(dm_valid), 32'd1); chk(g, "both_dm_rdata", dm_rdata, 32'hE3A5_5A3C);
            chk(g, "both_if_gnt_b2b", 32'(if_gnt), 32'd1);
            @(posedge clk); #1 if_req = 0;
            @(negedge clk); chk(g, "both_ce2_gap", 32'(mem_ce), 32'd1); chk(g, "both_addr2", mem_addr, 32'h104);
            repeat (L) @(negedge clk);
            chk(g, "both_if_valid", 32'(if_valid), 32'd1);
            // DM held with IF pending: four DM wins, then IF
            @(posedge clk); #1 if_addr = 32'h200; if_req = 1; dm_addr = 32'h300; dm_req = 1;
            n = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (if_gnt) break;
                n += int'(dm_gnt);
                @(posedge clk); #1;
            end
            chk(g, "starve_dm_wins", 32'(n), 32'd4); chk(g, "starve_if_wins", 32'(if_gnt), 32'd1);
            @(posedge clk); #1 if_req = 0; dm_req = 0;
            repeat (L + 2) @(posedge clk);
            // DM write
            #1 dm_we = 1; dm_sel = 4'b0011; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h400; dm_req = 1;
            @(negedge clk); chk(g, "wr_gnt", 32'(dm_gnt), 32'd1);
            @(posedge clk); #1 dm_req = 0; dm_we = 0;
            @(negedge clk);
            chk(g, "wr_mem_we", 32'(mem_we), 32'd1); chk(g, "wr_mem_sel", 32'(mem_sel), 32'b0011);
            chk(g, "wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            repeat (L) @(negedge clk);
            chk(g, "wr_dm_valid", 32'(dm_valid), 32'd1); chk(g, "wr_dm_rdata", dm_rdata, 32'd0);
            // reset while the access waits on memory
            @(posedge clk); #1 if_addr = 32'h500; if_req = 1;
            @(negedge clk); chk(g, "rst_pre_gnt", 32'(if_gnt), 32'd1);
            @(posedge clk); #1 if_req = 0;
            @(posedge clk); #1 rst = 0;
            @(negedge clk);
            chk(g, "rst_busy", 32'(busy), 32'd0); chk(g, "rst_if_valid", 32'(if_valid), 32'd0);
            chk(g, "rst_if_rdata", if_rdata, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst = 1;
            repeat (L + 2) begin
                @(negedge clk); chk(g, "no_valid_after_rst", 32'(if_valid), 32'd0);
            end
            @(posedge clk); #1 if_addr = 32'h600; if_req = 1;
            @(negedge clk); chk(g, "post_rst_gnt", 32'(if_gnt), 32'd1);
            @(posedge clk); #1 if_req = 0;
            repeat (L + 1) @(negedge clk);
            chk(g, "post_rst_valid", 32'(if_valid), 32'd1); chk(g, "post_rst_rdata", if_rdata, 32'hC5A5_5A3C);
`ifdef ARB_STATS_EN
            // 3 IF grants, 2 DM grants, one conflict cycle while busy
            @(posedge clk); #1 stat_clr = 1;
            @(posedge clk); #1 stat_clr = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (i < 3) begin if_addr = 32'h700 + 32'(i * 4); if_req = 1; end
                else begin dm_addr = 32'h800 + 32'(i * 4); dm_we = 0; dm_req = 1; end
                @(posedge clk); #1 if_req = 0; dm_req = 0;
                if (i == 4) begin
                    if_req = 1; dm_req = 1;
                    @(posedge clk); #1 if_req = 0; dm_req = 0;
                end
                repeat (L + 2) @(posedge clk);
            end
            @(negedge clk);
            chk(g, "stat_if_3", stat_if_cnt, 32'd3); chk(g, "stat_dm_2", stat_dm_cnt, 32'd2);
            chk(g, "stat_conf_1", stat_conf_cnt, 32'd1);
            @(posedge clk); #1 stat_clr = 1;
            @(posedge clk); #1 stat_clr = 0;
            @(negedge clk);
            chk(g, "stat_clr_zero", 32'(|{stat_if_cnt, stat_dm_cnt, stat_conf_cnt}), 32'd0);
`endif
            // random traffic, with DM-saturated phases and occasional resets
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk); ig = if_gnt; dg = dm_gnt;
                @(posedge clk); #1;
                noise = $urandom;
                rst = (c % 700) != 350;
                if (ig || !if_req) begin
                    if_req = $urandom_range(0, 99) < 50; if_addr = $urandom;
                end else if ($urandom_range(0, 99) < 3) if_req = 0;
                if (dg || !dm_req) begin
                    dm_req = ((c / 400) % 2 == 1) || $urandom_range(0, 99) < 50;
                    dm_we = 1'($urandom); dm_sel = 4'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
                end else if ($urandom_range(0, 99) < 3) dm_req = 0;
`ifdef ARB_STATS_EN
                stat_clr = $urandom_range(0, 99) == 0;
`endif
            end
            @(posedge clk); #1 if_req = 0; dm_req = 0; rst = 1;
            repeat (L + 3) @(posedge clk);
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(fin[0] && fin[1]); i++) @(posedge clk);
        if (!(fin[0] && fin[1])) begin
            total++;
            bad++;
            $display("FAIL timeout: lanes finished %0d/%0d, required 1/1", fin[0], fin[1]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
